// File: rtl/vram_write_arbiter_pkg.sv
// rtl/vram_write_arbiter_pkg.sv - shared types and constants for the VRAM write arbiter
// Purpose: arbiter state encoding, requester index enum, default VRAM cell count.
// Ports: none (package).
package vram_pkg;

    // 80 columns x 60 rows of character cells
    localparam int DEPTH_DEFAULT = 4800;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_CUR = 1'b1
    } req_t;

    function automatic req_t otherReq(input req_t r);
        return (r == REQ_CPU) ? REQ_CUR : REQ_CPU;
    endfunction

endpackage

// File: rtl/vram_write_arbiter_if.sv
// rtl/vram_write_arbiter_if.sv - requester, VRAM write and clear signals of the arbiter
// Purpose: bundles both write requesters, the VRAM write port and the clear controls.
// Ports: CPU requester (iCpuValid/oCpuReady/iCpuAddr/iCpuRGB), cursor requester
//        (iCurValid/oCurReady/iCurAddr/iCurRGB), VRAM port (oWriteEnable/oWriteAddress/
//        oDataIn), oAddrError, clear controls (iClear/iClearRGB/oBusy).
//        slave = arbiter side, master = requester/VRAM side.
interface vram_write_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 3
);
    logic              iCpuValid;
    logic              oCpuReady;
    logic [ADDR_W-1:0] iCpuAddr;
    logic [DATA_W-1:0] iCpuRGB;

    logic              iCurValid;
    logic              oCurReady;
    logic [ADDR_W-1:0] iCurAddr;
    logic [DATA_W-1:0] iCurRGB;

    logic              oWriteEnable;
    logic [ADDR_W-1:0] oWriteAddress;
    logic [DATA_W-1:0] oDataIn;
    logic              oAddrError;

    logic              iClear;
    logic [DATA_W-1:0] iClearRGB;
    logic              oBusy;

    modport slave (
        input  iCpuValid, iCpuAddr, iCpuRGB,
        input  iCurValid, iCurAddr, iCurRGB,
        input  iClear, iClearRGB,
        output oCpuReady, oCurReady,
        output oWriteEnable, oWriteAddress, oDataIn, oAddrError, oBusy
    );

    modport master (
        output iCpuValid, iCpuAddr, iCpuRGB,
        output iCurValid, iCurAddr, iCurRGB,
        output iClear, iClearRGB,
        input  oCpuReady, oCurReady,
        input  oWriteEnable, oWriteAddress, oDataIn, oAddrError, oBusy
    );
endinterface

// File: rtl/vram_write_arbiter_sync_fifo.sv
// rtl/vram_write_arbiter_sync_fifo.sv - per-requester synchronous FIFO, no bypass
// Purpose: DEPTH-entry (power of two) queue; pushes are ignored when full, pops when empty.
// Ports: Clock, Reset (async active-low), iPush/iData write side,
//        iPop/oData read side (oData shows the head), oEmpty, oFull.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iPush,
    input  logic [WIDTH-1:0] iData,
    input  logic             iPop,
    output logic [WIDTH-1:0] oData,
    output logic             oEmpty,
    output logic             oFull
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra wrap bit distinguishes full from empty when the indices match
    logic [PTR_W:0]   wrPtr;
    logic [PTR_W:0]   rdPtr;
    logic             doPush;
    logic             doPop;

    assign oEmpty = (wrPtr == rdPtr);
    assign oFull  = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                    (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
    assign oData  = mem[rdPtr[PTR_W-1:0]];
    assign doPush = iPush && !oFull;
    assign doPop  = iPop && !oEmpty;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + (PTR_W + 1)'(1);
            if (doPop)  rdPtr <= rdPtr + (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (doPush) mem[wrPtr[PTR_W-1:0]] <= iData;
    end

endmodule

// File: rtl/vram_write_arbiter.sv
// rtl/vram_write_arbiter.sv - two-requester round-robin VRAM write arbiter with optional clear
// Purpose: queues CPU and cursor pixel writes, drains at most one per cycle onto the
//          registered VRAM write port, flags out-of-range addresses (sticky).
//          Define VRAM_WRITE_ARBITER_CLEAR_EN to build the full-screen clear engine.
// Ports: Clock (rising edge), Reset (async active-low), bus (vram_write_arbiter_if.slave).
module vram_write_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 3,
    parameter int DEPTH      = DEPTH_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input logic                 Clock,
    input logic                 Reset,
    vram_write_arbiter_if.slave bus
);
    localparam int ENTRY_W = ADDR_W + DATA_W;

    logic               cpuPush, curPush, cpuPop, curPop;
    logic               cpuEmpty, curEmpty, cpuFull, curFull;
    logic [ENTRY_W-1:0] cpuEntry, curEntry, popped;
    logic [ADDR_W-1:0]  poppedAddr;
    logic [DATA_W-1:0]  poppedRgb;
    logic               inRange;
    logic               grantValid;
    req_t               grant;
    req_t               prio;       // requester favoured on the next tie
    logic               popEn;      // arbiter may drain a FIFO this cycle
    logic               clearWrite;
    logic [ADDR_W-1:0]  clearAddr;
    logic [DATA_W-1:0]  clearData;

    // Ready reflects fullness only, so a pop in the same cycle never opens a slot early
    assign bus.oCpuReady = !cpuFull;
    assign bus.oCurReady = !curFull;
    assign cpuPush = bus.iCpuValid && !cpuFull;
    assign curPush = bus.iCurValid && !curFull;

    sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) cpuFifo (
        .Clock (Clock),
        .Reset (Reset),
        .iPush (cpuPush),
        .iData ({bus.iCpuAddr, bus.iCpuRGB}),
        .iPop  (cpuPop),
        .oData (cpuEntry),
        .oEmpty(cpuEmpty),
        .oFull (cpuFull)
    );

    sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) curFifo (
        .Clock (Clock),
        .Reset (Reset),
        .iPush (curPush),
        .iData ({bus.iCurAddr, bus.iCurRGB}),
        .iPop  (curPop),
        .oData (curEntry),
        .oEmpty(curEmpty),
        .oFull (curFull)
    );

    always_comb begin
        grantValid = !cpuEmpty || !curEmpty;
        grant      = REQ_CPU;
        if (cpuEmpty)       grant = REQ_CUR;
        else if (!curEmpty) grant = prio;
    end

    assign cpuPop     = popEn && grantValid && (grant == REQ_CPU);
    assign curPop     = popEn && grantValid && (grant == REQ_CUR);
    assign popped     = (grant == REQ_CPU) ? cpuEntry : curEntry;
    assign poppedAddr = popped[ENTRY_W-1:DATA_W];
    assign poppedRgb  = popped[DATA_W-1:0];
    assign inRange    = 32'(poppedAddr) < 32'(DEPTH);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            prio <= REQ_CPU;
        end else if (cpuPop || curPop) begin
            prio <= otherReq(grant);
        end
    end

`ifdef VRAM_WRITE_ARBITER_CLEAR_EN
    localparam int CNT_W = $clog2(DEPTH);

    state_t            state, stateNext;
    logic [CNT_W-1:0]  clearCnt;
    logic [DATA_W-1:0] clearRgb;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= ST_IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:  if (bus.iClear) stateNext = ST_CLEAR;
            ST_CLEAR: if (clearCnt == CNT_W'(DEPTH - 1)) stateNext = ST_IDLE;
            default:  stateNext = ST_IDLE;
        endcase
    end

    // Colour is captured on entry so iClearRGB may change during the sweep
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clearCnt <= '0;
            clearRgb <= '0;
        end else if (state == ST_IDLE && bus.iClear) begin
            clearCnt <= '0;
            clearRgb <= bus.iClearRGB;
        end else if (state == ST_CLEAR) begin
            clearCnt <= clearCnt + CNT_W'(1);
        end
    end

    // The cycle that starts a clear does not drain a FIFO either
    assign popEn      = (state == ST_IDLE) && !bus.iClear;
    assign bus.oBusy  = (state == ST_CLEAR);
    assign clearWrite = (state == ST_CLEAR);
    assign clearAddr  = ADDR_W'(clearCnt);
    assign clearData  = clearRgb;
`else
    logic unusedClearInputs;

    assign unusedClearInputs = ^{bus.iClear, bus.iClearRGB};
    assign popEn      = 1'b1;
    assign bus.oBusy  = 1'b0;
    assign clearWrite = 1'b0;
    assign clearAddr  = '0;
    assign clearData  = '0;
`endif

    // Address/data hold their last values whenever no write is issued
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            bus.oWriteEnable  <= 1'b0;
            bus.oWriteAddress <= '0;
            bus.oDataIn       <= '0;
            bus.oAddrError    <= 1'b0;
        end else begin
            bus.oWriteEnable <= 1'b0;
            if (clearWrite) begin
                bus.oWriteEnable  <= 1'b1;
                bus.oWriteAddress <= clearAddr;
                bus.oDataIn       <= clearData;
            end else if (cpuPop || curPop) begin
                if (inRange) begin
                    bus.oWriteEnable  <= 1'b1;
                    bus.oWriteAddress <= poppedAddr;
                    bus.oDataIn       <= poppedRgb;
                end else begin
                    bus.oAddrError <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// tb/tb_vram_write_arbiter.sv - self-checking bench for vram_write_arbiter
module tb_vram_write_arbiter;
    localparam int ADDR_W     = 13;
    localparam int DATA_W     = 3;
    localparam int DEPTH      = 4800;
    localparam int FIFO_DEPTH = 4;
`ifdef VRAM_WRITE_ARBITER_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] rgb;
    } ent_t;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    vram_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vram_write_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model: two queues, a tie-break preference and the expected port values
    ent_t              cpuQ[$];
    ent_t              curQ[$];
    bit                favourCpu;
    bit                clearing;
    int                clearIdx;
    logic [DATA_W-1:0] clearRgb;
    logic              expWe;
    logic [ADDR_W-1:0] expAddr;
    logic [DATA_W-1:0] expData;
    logic              expErr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, exp);
        end
    endtask

    function automatic void modelReset();
        cpuQ.delete();
        curQ.delete();
        favourCpu = 1'b1;
        clearing  = 1'b0;
        clearIdx  = 0;
        clearRgb  = '0;
        expWe     = 1'b0;
        expAddr   = '0;
        expData   = '0;
        expErr    = 1'b0;
    endfunction

    function automatic void modelEdge();
        ent_t e;
        bit   pushCpu, pushCur, takeCpu;
        if (!Reset) begin
            modelReset();
            return;
        end
        pushCpu = bus.iCpuValid && (cpuQ.size() < FIFO_DEPTH);
        pushCur = bus.iCurValid && (curQ.size() < FIFO_DEPTH);
        expWe = 1'b0;
        if (clearing) begin
            expWe   = 1'b1;
            expAddr = ADDR_W'(clearIdx);
            expData = clearRgb;
            clearIdx++;
            if (clearIdx == DEPTH) clearing = 1'b0;
        end else if (CLEAR_EN && bus.iClear) begin
            clearing = 1'b1;
            clearIdx = 0;
            clearRgb = bus.iClearRGB;
        end else if (cpuQ.size() > 0 || curQ.size() > 0) begin
            takeCpu = (cpuQ.size() > 0) && (curQ.size() == 0 || favourCpu);
            if (takeCpu) e = cpuQ.pop_front();
            else         e = curQ.pop_front();
            favourCpu = !takeCpu;
            if (e.addr < DEPTH) begin
                expWe   = 1'b1;
                expAddr = e.addr;
                expData = e.rgb;
            end else begin
                expErr = 1'b1;
            end
        end
        if (pushCpu) cpuQ.push_back({bus.iCpuAddr, bus.iCpuRGB});
        if (pushCur) curQ.push_back({bus.iCurAddr, bus.iCurRGB});
    endfunction

    task automatic compareAll();
        check("write_enable", bus.oWriteEnable, expWe);
        check("write_address", bus.oWriteAddress, expAddr);
        check("data_in", bus.oDataIn, expData);
        check("addr_error", bus.oAddrError, expErr);
        check("cpu_ready", bus.oCpuReady, cpuQ.size() < FIFO_DEPTH);
        check("cur_ready", bus.oCurReady, curQ.size() < FIFO_DEPTH);
        check("busy", bus.oBusy, clearing);
    endtask

    task automatic tick();
        @(posedge Clock);
        modelEdge();
        @(negedge Clock);
        cycle++;
        compareAll();
    endtask

    task automatic idleInputs();
        bus.iCpuValid = 1'b0; bus.iCpuAddr = '0; bus.iCpuRGB = '0;
        bus.iCurValid = 1'b0; bus.iCurAddr = '0; bus.iCurRGB = '0;
        bus.iClear    = 1'b0; bus.iClearRGB = '0;
    endtask

    task automatic doReset();
        @(negedge Clock);
        idleInputs();
        Reset = 1'b0;
        #1;
        modelReset();
        compareAll();
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    logic [ADDR_W-1:0] seenAddr[$];
    int                seenCycle[$];
    logic [ADDR_W-1:0] exp31 [6];
    int  cpuNext, curNext, fullAt, cpuSeen, busyCnt, nextClr;
    bit  sawFull, found, cpuAfter;

    initial begin
        idleInputs();
        modelReset();
        repeat (2) @(negedge Clock);
        compareAll();
        Reset = 1'b1;

        // Single CPU write: accepted in cycle 0, visible in cycle 2 only
        bus.iCpuValid = 1'b1; bus.iCpuAddr = 13'h0105; bus.iCpuRGB = 3'b100;
        tick();
        idleInputs();
        check("single_c1_we", bus.oWriteEnable, 1'b0);
        tick();
        check("single_c2_we", bus.oWriteEnable, 1'b1);
        check("single_c2_addr", bus.oWriteAddress, 13'h0105);
        check("single_c2_data", bus.oDataIn, 3'd4);
        tick();
        check("single_c3_we", bus.oWriteEnable, 1'b0);
        check("single_c3_addr_hold", bus.oWriteAddress, 13'h0105);

        // Both requesters with three entries each: strict alternation starting with CPU
        doReset();
        seenAddr.delete();
        seenCycle.delete();
        for (int i = 0; i < 3; i++) begin
            bus.iCpuValid = 1'b1; bus.iCpuAddr = ADDR_W'(13'h10 + i); bus.iCpuRGB = 3'd1;
            bus.iCurValid = 1'b1; bus.iCurAddr = ADDR_W'(13'h20 + i); bus.iCurRGB = 3'd6;
            tick();
            if (bus.oWriteEnable) begin seenAddr.push_back(bus.oWriteAddress); seenCycle.push_back(cycle); end
        end
        idleInputs();
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.oWriteEnable) begin seenAddr.push_back(bus.oWriteAddress); seenCycle.push_back(cycle); end
        end
        exp31 = '{13'h10, 13'h20, 13'h11, 13'h21, 13'h12, 13'h22};
        check("rr_count", seenAddr.size(), 6);
        for (int i = 0; i < seenAddr.size() && i < 6; i++) begin
            check("rr_order", seenAddr[i], exp31[i]);
            if (i > 0) check("rr_consecutive", seenCycle[i] - seenCycle[i-1], 1);
        end

        // CPU saturation while the cursor competes: ready drops, order is preserved
        doReset();
        cpuNext = 0; curNext = 0; sawFull = 1'b0; fullAt = -1; cpuSeen = 0;
        for (int i = 0; i < 40; i++) begin
            bit acceptCpu, acceptCur;
            if (i < 14) begin
                bus.iCpuValid = 1'b1; bus.iCpuAddr = ADDR_W'(13'h100 + cpuNext); bus.iCpuRGB = 3'(cpuNext);
                bus.iCurValid = 1'b1; bus.iCurAddr = ADDR_W'(13'h200 + curNext); bus.iCurRGB = 3'(curNext);
            end else begin
                idleInputs();
            end
            acceptCpu = bus.iCpuValid && (cpuQ.size() < FIFO_DEPTH);
            acceptCur = bus.iCurValid && (curQ.size() < FIFO_DEPTH);
            tick();
            if (acceptCpu) cpuNext++;
            if (acceptCur) curNext++;
            if (!sawFull && bus.oCpuReady === 1'b0) begin sawFull = 1'b1; fullAt = cpuNext; end
            if (bus.oWriteEnable && bus.oWriteAddress >= 13'h100 && bus.oWriteAddress < 13'h200) begin
                check("sat_cpu_order", bus.oWriteAddress, 13'h100 + cpuSeen);
                cpuSeen++;
            end
        end
        check("sat_cpu_full_seen", sawFull, 1'b1);
        check("sat_pushes_before_full", fullAt, 7);
        check("sat_cpu_all_emitted", cpuSeen, cpuNext);

        // Out-of-range write: suppressed, sticky error survives a later good write
        doReset();
        bus.iCpuValid = 1'b1; bus.iCpuAddr = 13'd4800; bus.iCpuRGB = 3'd1;
        tick();
        idleInputs();
        tick();
        check("oor_we", bus.oWriteEnable, 1'b0);
        check("oor_err", bus.oAddrError, 1'b1);
        bus.iCpuValid = 1'b1; bus.iCpuAddr = 13'd5; bus.iCpuRGB = 3'd3;
        tick();
        idleInputs();
        tick();
        check("oor_next_we", bus.oWriteEnable, 1'b1);
        check("oor_next_addr", bus.oWriteAddress, 13'd5);
        check("oor_err_sticky", bus.oAddrError, 1'b1);

        // Randomized traffic against the model
        doReset();
        for (int i = 0; i < 400; i++) begin
            bus.iCpuValid = 1'($urandom_range(0, 1));
            bus.iCpuAddr  = ADDR_W'($urandom_range(0, 4899));
            bus.iCpuRGB   = DATA_W'($urandom);
            bus.iCurValid = 1'($urandom_range(0, 1));
            bus.iCurAddr  = ADDR_W'($urandom_range(0, 4899));
            bus.iCurRGB   = DATA_W'($urandom);
            bus.iClear    = CLEAR_EN ? 1'b0 : ($urandom_range(0, 7) == 0);
            bus.iClearRGB = DATA_W'($urandom);
            tick();
        end
        doReset();
        check("post_reset_we", bus.oWriteEnable, 1'b0);

`ifdef VRAM_WRITE_ARBITER_CLEAR_EN
        // Full-screen clear with a CPU write queued behind it
        doReset();
        bus.iClear = 1'b1; bus.iClearRGB = 3'b010;
        bus.iCpuValid = 1'b1; bus.iCpuAddr = 13'h0AB; bus.iCpuRGB = 3'd5;
        tick();
        idleInputs();
        busyCnt = 0; nextClr = 0; cpuAfter = 1'b0;
        for (int i = 0; i < 4810; i++) begin
            if (bus.oBusy) busyCnt++;
            tick();
            if (bus.oWriteEnable && bus.oDataIn == 3'd2 && bus.oWriteAddress == ADDR_W'(nextClr)) nextClr++;
            if (bus.oWriteEnable && bus.oWriteAddress == 13'h0AB && bus.oDataIn == 3'd5) cpuAfter = (nextClr == DEPTH);
        end
        check("clear_writes", nextClr, DEPTH);
        check("clear_busy_cycles", busyCnt, DEPTH);
        check("clear_cpu_after", cpuAfter, 1'b1);

        // Reset while the clear is at address 100
        doReset();
        bus.iClear = 1'b1; bus.iClearRGB = 3'b111;
        tick();
        idleInputs();
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            if (bus.oWriteEnable && bus.oWriteAddress == 13'd100) found = 1'b1;
        end
        check("abort_reached_addr100", found, 1'b1);
        #2;
        Reset = 1'b0;
        #1;
        modelReset();
        compareAll();
        @(negedge Clock);
        Reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("abort_no_write", bus.oWriteEnable, 1'b0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_write_arbiter.md
VRAM_WRITE_ARBITER -- requirements
Module: vram_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, meaning VRAM write address width ({row[5:0], col[6:0]}).
REQ-002 SHALL have parameter DATA_W, default 3, meaning RGB pixel width.
REQ-003 SHALL have parameter DEPTH, default 4800 (80*60), meaning the number of valid VRAM cells.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning the per-requester queue depth, a power of two.
REQ-005 SHALL have port Clock  in  1  system clock; all flops rising-edge.
REQ-006 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports iCpuValid in 1 / oCpuReady out 1 / iCpuAddr in ADDR_W / iCpuRGB in DATA_W, forming CPU (STC) write requester 0.
REQ-008 SHALL have ports iCurValid in 1 / oCurReady out 1 / iCurAddr in ADDR_W / iCurRGB in DATA_W, forming cursor/PS2 write requester 1.
REQ-009 SHALL have ports oWriteEnable out 1 / oWriteAddress out ADDR_W / oDataIn out DATA_W, driving the VRAM write port, all registered.
REQ-010 SHALL have port oAddrError  out  1, a sticky out-of-range flag.
REQ-011 SHALL have ports iClear in 1 (clear request pulse), iClearRGB in DATA_W (fill colour) and oBusy out 1 (clear in progress).

Function
REQ-012 SHALL accept a request when Valid and Ready are both high at a rising edge, pushing {Addr,RGB} into that requester's FIFO.
REQ-013 SHALL drive Ready = FIFO not full, evaluated before any same-cycle pop, with no bypass; push and pop in the same cycle on a non-full FIFO SHALL both occur.
REQ-014 SHALL, each cycle in IDLE state, pop at most one entry in total across both FIFOs.
REQ-015 SHALL pick the only non-empty FIFO if just one is non-empty; if both are non-empty, it SHALL pick the requester not granted last (round-robin).
REQ-016 SHALL update the last-granted pointer only on a pop; after reset the pointer SHALL favour CPU on the first tie.
REQ-017 SHALL register the popped entry onto oWriteAddress/oDataIn with oWriteEnable=1 for exactly one cycle; accepted in cycle k -> earliest oWriteEnable in cycle k+2.
REQ-018 SHALL, for a popped entry with address >= DEPTH, suppress oWriteEnable (0), set oAddrError, and still consume the entry.
REQ-019 SHALL hold oWriteAddress/oDataIn at their last values when oWriteEnable=0.
REQ-020 SHALL preserve per-requester FIFO order; no entry SHALL be lost or duplicated.
REQ-021 SHALL use state machine IDLE / CLEAR (CLEAR exists only per REQ-025).

Reset
REQ-022 SHALL, while Reset=0: empty both FIFOs, hold oWriteEnable=0, oWriteAddress=0, oDataIn=0, oAddrError=0, oBusy=0, state=IDLE, pointer=CPU, oCpuReady=oCurReady=1 after release.
REQ-023 SHALL, on reset mid-clear, abort immediately; no further clear writes SHALL follow.
REQ-024 SHALL clear oAddrError only by reset.

Configuration
REQ-025 SHALL implement the full-screen clear engine when VRAM_WRITE_ARBITER_CLEAR_EN is defined: iClear=1 in IDLE -> CLEAR next cycle; oBusy=1 in CLEAR; addresses 0..DEPTH-1 are written with iClearRGB latched at entry, one per cycle, linear counter mapped to {row,col}; IDLE follows after address DEPTH-1.
REQ-026 SHALL, in CLEAR, pop no FIFOs; Ready keeps following fullness; iClear SHALL be ignored in CLEAR.
REQ-027 SHALL, without the macro, ignore iClear, tie oBusy=0, and omit the CLEAR state and counter.

Structure
REQ-028 SHALL take state encoding, the requester index enum and DEPTH default from the shared package (vram_pkg).
REQ-029 SHALL instantiate one sub-module sync_fifo (params WIDTH=ADDR_W+DATA_W, DEPTH=FIFO_DEPTH) twice.

Verification
REQ-030 SHALL cover: single CPU write addr 0x0105 rgb 3'b100 accepted cycle 0 -> oWriteEnable=1, addr 0x0105, data 4 in cycle 2 only.
REQ-031 SHALL cover: both requesters hold Valid with 3 entries each -> grants alternate CPU,CUR,CPU,CUR,CPU,CUR on 6 consecutive cycles.
REQ-032 SHALL cover: CPU pushes 5 entries back-to-back while the cursor is busy -> oCpuReady=0 after 4 pushes, 5th accepted later, order preserved.
REQ-033 SHALL cover: CPU write addr 13'd4800 -> no oWriteEnable, oAddrError=1 and stays 1 after a following valid write.
REQ-034 SHALL cover (CLEAR_EN): iClear pulse with iClearRGB=3'b010 -> 4800 consecutive writes addr 0..4799 data 2, oBusy high 4800 cycles, queued CPU write emitted after.
REQ-035 SHALL cover: Reset=0 asserted during clear at address 100 -> outputs zero asynchronously, no writes after release until a new request.
